// File: rtl/seg7_scan_capture.sv
// Scanned 7-segment bus receiver: samples the active-low anode/segment bus,
// decodes each stable pattern back to BCD and flags complete scan frames.
module seg7_scan_capture #(
    parameter int NDIG       = 8,
    parameter int STABLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NDIG-1:0]     an_n,
    input  logic [6:0]          seg_n,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     blank,
    output logic [NDIG-1:0]     err,
    output logic                frame_valid,
    output logic                bad_an
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    localparam logic [3:0]      CNT_SAT  = 4'(STABLE_CYC);
    localparam logic [3:0]      CNT_LAST = 4'(STABLE_CYC - 1);
    localparam logic [NDIG-1:0] ONE      = NDIG'(1);

    state_t          state;
    logic [3:0]      cnt;
    logic [NDIG-1:0] an_q;
    logic [6:0]      seg_q;
    logic [NDIG-1:0] seen;

    logic            same;
    logic            any_low;
    logic [NDIG-1:0] sel;
    logic            one_hot;
    logic            done;
    logic            cap;
    logic [NDIG-1:0] seen_nxt;
    logic            frame_done;
    logic [5:0]      dec;

    // Returns {err, blank, bcd} for one active-low segment pattern
    function automatic logic [5:0] dec7(input logic [6:0] s);
        logic [5:0] r;
        r = 6'b10_0000;
        case (s)
            7'b1000000: r = 6'b00_0000;
            7'b1111001: r = 6'b00_0001;
            7'b0100100: r = 6'b00_0010;
            7'b0110000: r = 6'b00_0011;
            7'b0011001: r = 6'b00_0100;
            7'b0010010: r = 6'b00_0101;
            7'b0000010: r = 6'b00_0110;
            7'b1111000: r = 6'b00_0111;
            7'b0000000: r = 6'b00_1000;
            7'b0010000: r = 6'b00_1001;
            7'b1111111: r = 6'b01_0000;
            default:    r = 6'b10_0000;
        endcase
        return r;
    endfunction

    // Stability, select validity and capture decisions
    always_comb begin
        same       = (an_n == an_q) && (seg_n == seg_q);
        any_low    = ~&an_n;
        sel        = ~an_q;
        one_hot    = (sel != '0) && ((sel & (sel - ONE)) == '0);
        done       = (state == SETTLE) && same && (cnt == CNT_LAST);
        cap        = done && one_hot;
        seen_nxt   = seen | (cap ? sel : '0);
        frame_done = cap && (&seen_nxt);
        dec        = dec7(seg_q);
    end

    // Input sample registers
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= '1;
            seg_q <= '1;
        end else begin
            an_q  <= an_n;
            seg_q <= seg_n;
        end
    end

    // Settle/hold state machine with saturating stability counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (!same) begin
            cnt   <= '0;
            state <= any_low ? SETTLE : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                end
                SETTLE: begin
                    if (cnt != CNT_SAT) cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) state <= HOLD;
                end
                HOLD: begin
                    if (cnt != CNT_SAT) cnt <= cnt + 4'd1;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Captured digit store, frame tracking and select error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            digits      <= '0;
            blank       <= '1;
            err         <= '0;
            seen        <= '0;
            frame_valid <= 1'b0;
            bad_an      <= 1'b0;
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                if (cap && sel[i]) begin
                    digits[4*i +: 4] <= dec[3:0];
                    blank[i]         <= dec[4];
                    err[i]           <= dec[5];
                end
            end
            seen        <= frame_done ? '0 : seen_nxt;
            frame_valid <= frame_done;
            if (done && !one_hot) bad_an <= 1'b1;
        end
    end

endmodule
